// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and RAM-side signals of mem_arbiter.
// The slave modport is the arbiter's view; master is the requesters + RAM.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_valid;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_q,
    output i_rdata, i_valid, d_rdata, d_valid, mem_addr, mem_data, mem_wren, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_q,
    input  i_rdata, i_valid, d_rdata, d_valid, mem_addr, mem_data, mem_wren, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises a fetch (read-only) port and a data (read/write)
// port onto one single-port RAM, one transaction at a time.
// Optional macro MEM_ARBITER_ROUND_ROBIN_EN: ties go to the port not served
// last; without it the data port always wins a tie.
// RD_LAT (legal 1..3) is the RAM latency from registered address to mem_q.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic         Clock,
  input  logic         Resetn,
  mem_arbiter_if.slave bus
);
  localparam int unsigned     CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              txn_we;
  logic              txn_dport;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic              mem_wren_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              i_valid_q;
  logic              d_valid_q;
  logic              busy_q;
  logic              grant_d;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_d;

  // A lone request always wins; a tie goes to the port not served last.
  assign grant_d = bus.d_req && (!bus.i_req || !last_d);

  // Remember which port took the most recent grant (data after reset).
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      last_d <= 1'b1;
    end else if (state == IDLE && (bus.i_req || bus.d_req)) begin
      last_d <= grant_d;
    end
  end
`else
  assign grant_d = bus.d_req;
`endif

  // Transaction FSM: grant, drive RAM, wait out read latency, respond.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      txn_we     <= 1'b0;
      txn_dport  <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_wren_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_valid_q  <= 1'b0;
      d_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      mem_wren_q <= 1'b0;
      i_valid_q  <= 1'b0;
      d_valid_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            txn_dport  <= grant_d;
            txn_we     <= grant_d && bus.d_we;
            mem_addr_q <= grant_d ? bus.d_addr : bus.i_addr;
            mem_data_q <= grant_d ? bus.d_wdata : '0;
            mem_wren_q <= grant_d && bus.d_we;
            busy_q     <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (txn_we) begin
            d_valid_q <= txn_dport;
            i_valid_q <= !txn_dport;
            state     <= RESP;
          end else begin
            cnt   <= CNT_LOAD;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (txn_dport) begin
              d_rdata_q <= bus.mem_q;
              d_valid_q <= 1'b1;
            end else begin
              i_rdata_q <= bus.mem_q;
              i_valid_q <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.mem_wren = mem_wren_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.i_valid  = i_valid_q;
  assign bus.d_valid  = d_valid_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: three arbiters (RD_LAT 1, 2, 3) driven by the same
// requests, each with its own RAM and transaction-level reference model.
module tb_mem_arbiter;
  localparam int unsigned NL = 3;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Lane outputs mirrored to flat arrays for the directed checks.
  logic [15:0] o_ird[NL], o_drd[NL], o_maddr[NL];
  logic        o_busy[NL], o_wren[NL], o_iv[NL], o_dv[NL];

  // Per-lane observations since the last clear or reset.
  int          n_i[NL], n_d[NL], n_w[NL], iv_cyc[NL], dv_cyc[NL], w_cyc[NL], nord[NL];
  logic [15:0] w_addr[NL];
  logic [7:0]  ord[NL];

  // Read valid is high at the check after edge s+N, s = sampling edge.
  int rd_vis[NL]    = '{2, 3, 4};
  int fetch_vis[NL] = '{6, 8, 10};

  initial forever #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input int a);
    if (a == 16) return 16'hBEEF;
    return 16'(a * 257 + 4096);
  endfunction

  task automatic chk(input string nm, input int ln, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d actual=%0h required=%0h", nm, ln, act, exp);
    end
  endtask

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int unsigned LAT = g + 1;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(LAT)) dut (
      .Clock (Clock),
      .Resetn(Resetn),
      .bus   (bus)
    );

    assign bus.i_req   = i_req;
    assign bus.i_addr  = i_addr;
    assign bus.d_req   = d_req;
    assign bus.d_we    = d_we;
    assign bus.d_addr  = d_addr;
    assign bus.d_wdata = d_wdata;

    assign o_ird[g]   = bus.i_rdata;
    assign o_drd[g]   = bus.d_rdata;
    assign o_maddr[g] = bus.mem_addr;
    assign o_busy[g]  = bus.busy;
    assign o_wren[g]  = bus.mem_wren;
    assign o_iv[g]    = bus.i_valid;
    assign o_dv[g]    = bus.d_valid;

    logic [15:0] ram[256];
    logic [15:0] qp[LAT];
    logic [15:0] mm[256];

    assign bus.mem_q = qp[LAT-1];

    // RAM with a LAT-deep read pipeline.
    initial begin
      for (int a = 0; a < 256; a++) ram[a] = init_val(a);
      for (int k = 0; k < int'(LAT); k++) qp[k] = 16'h0;
      forever begin
        @(posedge Clock);
        qp[0] <= ram[bus.mem_addr[7:0]];
        for (int k = 1; k < int'(LAT); k++) qp[k] <= qp[k-1];
        if (bus.mem_wren) ram[bus.mem_addr[7:0]] = bus.mem_data;
      end
    end

    // Reference: each grant makes the arbiter busy for a fixed number of
    // cycles (2 for a write, LAT+2 for a read); valid is in the last one.
    initial begin : model
      int          rem, len;
      logic        we_m, dp_m;
      logic [15:0] addr_m, wd_m, ir_m, dr_m;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      logic        last_dm;
      last_dm = 1'b1;
`endif
      for (int a = 0; a < 256; a++) mm[a] = init_val(a);
      rem = 0; len = 0; we_m = 1'b0; dp_m = 1'b0;
      addr_m = 16'h0; wd_m = 16'h0; ir_m = 16'h0; dr_m = 16'h0;
      forever begin
        @(posedge Clock);
        if (!Resetn) begin
          rem = 0; we_m = 1'b0; addr_m = 16'h0; ir_m = 16'h0; dr_m = 16'h0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
          last_dm = 1'b1;
`endif
        end else if (rem > 0) begin
          rem--;
          if (rem == 1 && !we_m) begin
            if (dp_m) dr_m = mm[addr_m[7:0]];
            else      ir_m = mm[addr_m[7:0]];
          end
        end else if (i_req || d_req) begin
          if (i_req && d_req) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            dp_m = !last_dm;
`else
            dp_m = 1'b1;
`endif
          end else begin
            dp_m = d_req;
          end
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
          last_dm = dp_m;
`endif
          we_m   = dp_m && d_we;
          addr_m = dp_m ? d_addr : i_addr;
          wd_m   = d_wdata;
          len    = we_m ? 2 : int'(LAT) + 2;
          rem    = len;
          if (we_m) mm[addr_m[7:0]] = wd_m;
        end
        #1;
        chk("busy",     g, 32'(bus.busy),     32'(rem > 0));
        chk("mem_wren", g, 32'(bus.mem_wren), 32'(we_m && rem > 0 && rem == len));
        chk("i_valid",  g, 32'(bus.i_valid),  32'(rem == 1 && !dp_m));
        chk("d_valid",  g, 32'(bus.d_valid),  32'(rem == 1 && dp_m));
        chk("mem_addr", g, 32'(bus.mem_addr), 32'(addr_m));
        chk("i_rdata",  g, 32'(bus.i_rdata),  32'(ir_m));
        chk("d_rdata",  g, 32'(bus.d_rdata),  32'(dr_m));
        if (we_m && rem > 0 && rem == len) chk("mem_data", g, 32'(bus.mem_data), 32'(wd_m));
        if (!Resetn) begin
          n_i[g] = 0; n_d[g] = 0; n_w[g] = 0; nord[g] = 0; ord[g] = 8'h0;
        end else begin
          if (bus.i_valid) begin
            n_i[g]++; iv_cyc[g] = cyc;
            if (nord[g] < 8) ord[g][nord[g]] = 1'b0;
            nord[g]++;
          end
          if (bus.d_valid) begin
            n_d[g]++; dv_cyc[g] = cyc;
            if (nord[g] < 8) ord[g][nord[g]] = 1'b1;
            nord[g]++;
          end
          if (bus.mem_wren) begin
            n_w[g]++; w_addr[g] = bus.mem_addr; w_cyc[g] = cyc;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #2;
  endtask

  task automatic clr();
    for (int g = 0; g < int'(NL); g++) begin
      n_i[g] = 0; n_d[g] = 0; n_w[g] = 0; nord[g] = 0; ord[g] = 8'h0;
      iv_cyc[g] = -1; dv_cyc[g] = -1; w_cyc[g] = -1; w_addr[g] = 16'h0;
    end
  endtask

  initial begin : main
    int s;
    Resetn = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    clr();
    step(2);
    for (int g = 0; g < int'(NL); g++) begin
      chk("rst_busy",  g, 32'(o_busy[g]),  32'h0);
      chk("rst_ird",   g, 32'(o_ird[g]),   32'h0);
      chk("rst_drd",   g, 32'(o_drd[g]),   32'h0);
      chk("rst_maddr", g, 32'(o_maddr[g]), 32'h0);
    end
    Resetn = 1'b1;
    step(1);

    // Fetch read of 0x0010.
    clr();
    s = cyc + 1; i_req = 1'b1; i_addr = 16'h0010;
    step(1); i_req = 1'b0;
    step(8);
    for (int g = 0; g < int'(NL); g++) begin
      chk("fetch_lat",   g, 32'(iv_cyc[g]), 32'(s + rd_vis[g]));
      chk("fetch_pulse", g, 32'(n_i[g]),    32'h1);
      chk("fetch_no_dv", g, 32'(n_d[g]),    32'h0);
      chk("fetch_data",  g, 32'(o_ird[g]),  32'hBEEF);
    end

    // Data write 0x1234 to 0x0020.
    clr();
    s = cyc + 1; d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
    step(1); d_req = 1'b0; d_we = 1'b0;
    step(6);
    for (int g = 0; g < int'(NL); g++) begin
      chk("wr_lat",    g, 32'(dv_cyc[g]), 32'(s + 1));
      chk("wr_wren_n", g, 32'(n_w[g]),    32'h1);
      chk("wr_wren_t", g, 32'(w_cyc[g]),  32'(s));
      chk("wr_addr",   g, 32'(w_addr[g]), 32'h0020);
      chk("wr_drd",    g, 32'(o_drd[g]),  32'h0);
    end

    // Data read back of 0x0020.
    clr();
    s = cyc + 1; d_req = 1'b1; d_addr = 16'h0020;
    step(1); d_req = 1'b0;
    step(8);
    for (int g = 0; g < int'(NL); g++) begin
      chk("rd_lat",  g, 32'(dv_cyc[g]), 32'(s + rd_vis[g]));
      chk("rd_data", g, 32'(o_drd[g]),  32'h1234);
      chk("rd_ird",  g, 32'(o_ird[g]),  32'hBEEF);
      chk("rd_nowr", g, 32'(n_w[g]),    32'h0);
    end

    // Tie from reset with both ports reading.
    clr();
    Resetn = 1'b0;
    step(1);
    Resetn = 1'b1;
    s = cyc + 1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 16'h0010; d_addr = 16'h0020;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    step(24); i_req = 1'b0; d_req = 1'b0;
    step(8);
    for (int g = 0; g < int'(NL); g++) begin
      chk("rr_count", g, 32'(nord[g] >= 4), 32'h1);
      chk("rr_order", g, 32'(ord[g][3:0]),  32'hA);
    end
`else
    step(1); d_req = 1'b0;
    step(6); i_req = 1'b0;
    step(8);
    for (int g = 0; g < int'(NL); g++) begin
      chk("tie_order", g, 32'(ord[g][1:0]), 32'h1);
      chk("tie_count", g, 32'(nord[g]),     32'h2);
      chk("tie_d_lat", g, 32'(dv_cyc[g]),   32'(s + rd_vis[g]));
      chk("tie_i_lat", g, 32'(iv_cyc[g]),   32'(s + fetch_vis[g]));
    end
`endif

    // Reset while a write sits in ISSUE.
    clr();
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'hDEAD;
    step(1);
    for (int g = 0; g < int'(NL); g++) chk("issue_wren", g, 32'(o_wren[g]), 32'h1);
    d_req = 1'b0; d_we = 1'b0; Resetn = 1'b0;
    #1;
    for (int g = 0; g < int'(NL); g++) begin
      chk("rstw_wren", g, 32'(o_wren[g]), 32'h0);
      chk("rstw_busy", g, 32'(o_busy[g]), 32'h0);
    end
    step(1); Resetn = 1'b1;
    step(6);
    for (int g = 0; g < int'(NL); g++) chk("rstw_no_dv", g, 32'(n_d[g]), 32'h0);

    // Reset while the RD_LAT=3 lane is waiting on the RAM.
    clr();
    d_req = 1'b1; d_addr = 16'h0020;
    step(1); d_req = 1'b0;
    step(2);
    chk("wait_busy", 2, 32'(o_busy[2]), 32'h1);
    Resetn = 1'b0;
    #1;
    for (int g = 0; g < int'(NL); g++) begin
      chk("rstr_busy",  g, 32'(o_busy[g]),  32'h0);
      chk("rstr_dv",    g, 32'(o_dv[g]),    32'h0);
      chk("rstr_iv",    g, 32'(o_iv[g]),    32'h0);
      chk("rstr_drd",   g, 32'(o_drd[g]),   32'h0);
      chk("rstr_ird",   g, 32'(o_ird[g]),   32'h0);
      chk("rstr_maddr", g, 32'(o_maddr[g]), 32'h0);
    end
    step(1); Resetn = 1'b1;
    step(8);
    for (int g = 0; g < int'(NL); g++) chk("rstr_no_dv", g, 32'(n_d[g]), 32'h0);

    // Normal fetch after the aborted read.
    clr();
    s = cyc + 1; i_req = 1'b1; i_addr = 16'h0010;
    step(1); i_req = 1'b0;
    step(8);
    for (int g = 0; g < int'(NL); g++) begin
      chk("post_lat",  g, 32'(iv_cyc[g]), 32'(s + rd_vis[g]));
      chk("post_data", g, 32'(o_ird[g]),  32'hBEEF);
      chk("post_drd",  g, 32'(o_drd[g]),  32'h0);
      chk("post_n",    g, 32'(n_i[g]),    32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
